scan_seq_ctrl: RTL and testbench

SCAN_SEQ_CTRL -- requirements
Module: scan_seq_ctrl

---
 rtl/scan_seq_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_scan_seq_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : scan_seq_ctrl                                              |
// | Brief   : Sequences ADPLL lock qualification, scan runs and retries. |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module scan_seq_ctrl #(
  parameter int RETRY_MAX  = 3,
  parameter int GAP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        adpll_lock,
  input  logic        scan_done,
  input  logic [19:0] cfg_scan_num,
  input  logic [3:0]  cfg_runs,
  input  logic [7:0]  cfg_lock_cycles,
  input  logic [15:0] cfg_timeout,
  output logic        scan_en,
  output logic [19:0] scan_num,
  output logic [3:0]  run_idx,
  output logic [1:0]  retry_cnt,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_SCAN      = 3'd2,
    S_GAP       = 3'd3,
    S_DONE      = 3'd4,
    S_ERROR     = 3'd5
  } state_t;

  localparam logic [15:0] C_GAP_LAST = 16'(GAP_CYCLES - 1);

  state_t      r_state, w_state_nxt;
  logic        r_scan_en;
  logic [19:0] r_scan_num;
  logic [3:0]  r_cfg_runs;
  logic [7:0]  r_cfg_lock;
  logic [15:0] r_cfg_tmo;
  logic [7:0]  r_lock_cnt, w_lock_nxt, w_lock_inc;
  logic [15:0] r_tmo, w_tmo_nxt, w_tmo_inc;
  logic [15:0] r_gap, w_gap_nxt;
  logic [3:0]  r_run, w_run_nxt, w_run_inc;
  logic [7:0]  r_retry, w_retry_nxt, w_retry_inc;
  logic [1:0]  r_err, w_err_nxt;
  logic        w_latch;
  logic        w_can_start;
  logic        w_locked;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_scan_en  <= 1'b0;
      r_scan_num <= '0;
      r_cfg_runs <= '0;
      r_cfg_lock <= '0;
      r_cfg_tmo  <= '0;
      r_lock_cnt <= '0;
      r_tmo      <= '0;
      r_gap      <= '0;
      r_run      <= '0;
      r_retry    <= '0;
      r_err      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_scan_en  <= (w_state_nxt == S_SCAN);
      r_lock_cnt <= w_lock_nxt;
      r_tmo      <= w_tmo_nxt;
      r_gap      <= w_gap_nxt;
      r_run      <= w_run_nxt;
      r_retry    <= w_retry_nxt;
      r_err      <= w_err_nxt;
      if (w_latch) begin
        r_scan_num <= cfg_scan_num;
        r_cfg_runs <= cfg_runs;
        r_cfg_lock <= cfg_lock_cycles;
        r_cfg_tmo  <= cfg_timeout;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_lock_nxt  = r_lock_cnt;
    w_tmo_nxt   = r_tmo;
    w_gap_nxt   = r_gap;
    w_run_nxt   = r_run;
    w_retry_nxt = r_retry;
    w_err_nxt   = r_err;
    w_latch     = 1'b0;
    w_lock_inc  = (r_lock_cnt == 8'hFF) ? 8'hFF : r_lock_cnt + 8'd1;
    w_tmo_inc   = r_tmo + 16'd1;
    w_run_inc   = r_run + 4'd1;
    w_retry_inc = r_retry + 8'd1;
    w_can_start = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR);
    // A zero lock requirement qualifies on the first high sample; otherwise
    // the registered run length must already have reached the target.
    w_locked    = (r_cfg_lock == 8'd0) ? adpll_lock : (r_lock_cnt == r_cfg_lock);

    if (abort) begin
      w_state_nxt = S_IDLE;
    end else if (start && w_can_start) begin
      w_latch     = 1'b1;
      w_run_nxt   = '0;
      w_retry_nxt = '0;
      w_err_nxt   = 2'd0;
      w_tmo_nxt   = '0;
      w_lock_nxt  = '0;
      w_state_nxt = (cfg_runs == 4'd0) ? S_DONE : S_WAIT_LOCK;
    end else begin
      case (r_state)
        S_WAIT_LOCK: begin
          w_tmo_nxt  = w_tmo_inc;
          w_lock_nxt = adpll_lock ? w_lock_inc : 8'd0;
          if (w_locked) begin
            w_state_nxt = S_SCAN;
          end else if ((r_cfg_tmo != 16'd0) && (w_tmo_inc == r_cfg_tmo)) begin
            w_state_nxt = S_ERROR;
            w_err_nxt   = 2'd1;
          end
        end
        S_SCAN: begin
          // scan_done wins over a simultaneous lock loss
          if (scan_done) begin
            w_run_nxt = w_run_inc;
            if (w_run_inc == r_cfg_runs) begin
              w_state_nxt = S_DONE;
            end else if (GAP_CYCLES == 0) begin
              w_state_nxt = S_WAIT_LOCK;
              w_tmo_nxt   = '0;
              w_lock_nxt  = '0;
            end else begin
              w_state_nxt = S_GAP;
              w_gap_nxt   = '0;
            end
          end else if (!adpll_lock) begin
            if (int'(w_retry_inc) > RETRY_MAX) begin
              w_state_nxt = S_ERROR;
              w_err_nxt   = 2'd2;
            end else begin
              w_retry_nxt = w_retry_inc;
              w_state_nxt = S_WAIT_LOCK;
              w_tmo_nxt   = '0;
              w_lock_nxt  = '0;
            end
          end
        end
        S_GAP: begin
          if (r_gap == C_GAP_LAST) begin
            w_state_nxt = S_WAIT_LOCK;
            w_tmo_nxt   = '0;
            w_lock_nxt  = '0;
          end else begin
            w_gap_nxt = r_gap + 16'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign scan_en   = r_scan_en;
  assign scan_num  = r_scan_num;
  assign run_idx   = r_run;
  assign retry_cnt = (r_retry > 8'd3) ? 2'd3 : r_retry[1:0];
  assign busy      = (r_state == S_WAIT_LOCK) || (r_state == S_SCAN) || (r_state == S_GAP);
  assign done      = (r_state == S_DONE);
  assign error     = (r_state == S_ERROR);
  assign err_code  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_scan_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_scan_seq_ctrl                                           |
// | Brief   : Randomised scenario bench for scan_seq_ctrl.               |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_scan_seq_ctrl;

  localparam int GAP  = 4;
  localparam int RMAX = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        adpll_lock = 1'b0;
  logic        scan_done = 1'b0;
  logic [19:0] cfg_scan_num = '0;
  logic [3:0]  cfg_runs = '0;
  logic [7:0]  cfg_lock_cycles = '0;
  logic [15:0] cfg_timeout = '0;
  logic        scan_en;
  logic [19:0] scan_num;
  logic [3:0]  run_idx;
  logic [1:0]  retry_cnt;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  err_code;

  int vec  = 0;
  int errs = 0;

  scan_seq_ctrl #(.RETRY_MAX(RMAX), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .adpll_lock(adpll_lock), .scan_done(scan_done),
    .cfg_scan_num(cfg_scan_num), .cfg_runs(cfg_runs),
    .cfg_lock_cycles(cfg_lock_cycles), .cfg_timeout(cfg_timeout),
    .scan_en(scan_en), .scan_num(scan_num), .run_idx(run_idx),
    .retry_cnt(retry_cnt), .busy(busy), .done(done), .error(error),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Samples between accepted start (or WAIT_LOCK entry) and SCAN with lock held high
  function automatic int lock_latency(input int lk);
    return (lk == 0) ? 1 : lk + 1;
  endfunction

  // SCAN-entry sample for an arbitrary lock pattern: the run of consecutive
  // high cycles before a sample must already equal the target.
  function automatic int pattern_latency(input logic [63:0] pat, input int lk);
    int run = 0;
    for (int k = 0; k < 200; k++) begin
      logic b;
      b = (k < 64) ? pat[k] : 1'b1;
      if (lk == 0) begin
        if (b) return k + 1;
      end else if (run == lk) begin
        return k + 1;
      end
      run = b ? run + 1 : 0;
    end
    return -1;
  endfunction

  task automatic do_start(input int runs, input int lk, input int tmo, input logic [19:0] sn);
    cfg_runs = 4'(runs); cfg_lock_cycles = 8'(lk); cfg_timeout = 16'(tmo); cfg_scan_num = sn;
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_runs = 4'($urandom); cfg_lock_cycles = 8'($urandom);
    cfg_timeout = 16'($urandom); cfg_scan_num = 20'($urandom);
  endtask

  task automatic wait_scan(output int n);
    n = -1;
    for (int k = 0; k < 400; k++) begin
      if (scan_en === 1'b1) begin
        n = k;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; adpll_lock = 1'b1; scan_done = 1'b1;
    cfg_runs = 4'd5; cfg_scan_num = 20'hABCDE;
    repeat (3) tick();
    vec++; if ({scan_en, busy, done, error} !== 4'b0000) begin
      errs++; $display("FAIL reset_flags got %b exp 0000", {scan_en, busy, done, error});
    end
    vec++; if (scan_num !== 20'd0 || run_idx !== 4'd0 || retry_cnt !== 2'd0 || err_code !== 2'd0) begin
      errs++; $display("FAIL reset_counts got num=%h run=%0d retry=%0d err=%0d exp all 0",
                       scan_num, run_idx, retry_cnt, err_code);
    end
    start = 1'b0; scan_done = 1'b0; adpll_lock = 1'b0;
    rst_n = 1'b1;
    tick();
    vec++; if (busy !== 1'b0 || done !== 1'b0) begin
      errs++; $display("FAIL reset_idle got busy=%b done=%b exp 0 0", busy, done);
    end
  endtask

  task automatic test_async_reset();
    adpll_lock = 1'b1;
    do_start(1, 0, 0, 20'h12345);
    tick();
    vec++; if (scan_en !== 1'b1) begin
      errs++; $display("FAIL areset_pre got scan_en=%b exp 1", scan_en);
    end
    #3 rst_n = 1'b0;
    #1;
    vec++; if (scan_en !== 1'b0 || busy !== 1'b0 || scan_num !== 20'd0) begin
      errs++; $display("FAIL areset_drop got scan_en=%b busy=%b num=%h exp 0 0 0", scan_en, busy, scan_num);
    end
    tick();
    rst_n = 1'b1; adpll_lock = 1'b0;
    tick();
  endtask

  task automatic test_nominal(input int iter);
    int runs, lk, n, w;
    logic [19:0] sn;
    runs = (iter == 0) ? 2 : int'($urandom_range(1, 4));
    lk   = (iter == 0) ? 3 : int'($urandom_range(0, 6));
    sn   = 20'($urandom);
    w    = lock_latency(lk);
    adpll_lock = 1'b1;
    do_start(runs, lk, 0, sn);
    for (int r = 0; r < runs; r++) begin
      wait_scan(n);
      vec++; if (n !== w) begin
        errs++; $display("FAIL nom_lock_latency run %0d got %0d exp %0d", r, n, w);
      end
      vec++; if (scan_num !== sn || run_idx !== 4'(r) || busy !== 1'b1) begin
        errs++; $display("FAIL nom_scan_state got num=%h run=%0d busy=%b exp %h %0d 1", scan_num, run_idx, busy, sn, r);
      end
      repeat ($urandom_range(0, 3)) tick();
      vec++; if (scan_en !== 1'b1) begin
        errs++; $display("FAIL nom_scan_hold got %b exp 1", scan_en);
      end
      scan_done = 1'b1;
      tick();
      scan_done = 1'b0;
      if (r + 1 < runs) begin
        for (int g = 0; g < GAP; g++) begin
          vec++; if (scan_en !== 1'b0 || busy !== 1'b1 || run_idx !== 4'(r + 1)) begin
            errs++; $display("FAIL nom_gap got scan_en=%b busy=%b run=%0d exp 0 1 %0d", scan_en, busy, run_idx, r + 1);
          end
          tick();
        end
      end
    end
    vec++; if (done !== 1'b1 || busy !== 1'b0 || scan_en !== 1'b0 || run_idx !== 4'(runs)) begin
      errs++; $display("FAIL nom_done got done=%b busy=%b scan_en=%b run=%0d exp 1 0 0 %0d", done, busy, scan_en, run_idx, runs);
    end
    repeat (3) tick();
    vec++; if (done !== 1'b1 || run_idx !== 4'(runs)) begin
      errs++; $display("FAIL nom_done_hold got done=%b run=%0d exp 1 %0d", done, run_idx, runs);
    end
  endtask

  task automatic test_timeout(input int t, input bit glitch);
    int early = 0;
    adpll_lock = 1'b0;
    do_start(1, 20, t, 20'h1);
    for (int k = 0; k < t; k++) begin
      if (busy !== 1'b1 || error !== 1'b0) early++;
      adpll_lock = (glitch && (k % 8 != 7)) ? 1'($urandom) : 1'b0;
      tick();
    end
    vec++; if (early !== 0) begin
      errs++; $display("FAIL tmo_early got %0d bad samples exp 0", early);
    end
    vec++; if (error !== 1'b1 || err_code !== 2'd1 || busy !== 1'b0) begin
      errs++; $display("FAIL tmo_error t=%0d got error=%b code=%0d busy=%b exp 1 1 0", t, error, err_code, busy);
    end
    adpll_lock = 1'b0;
    repeat (5) tick();
    vec++; if (error !== 1'b1 || err_code !== 2'd1) begin
      errs++; $display("FAIL tmo_hold got error=%b code=%0d exp 1 1", error, err_code);
    end
    do_start(2, 20, 0, 20'h2);
    vec++; if (error !== 1'b0 || err_code !== 2'd0 || busy !== 1'b1) begin
      errs++; $display("FAIL tmo_restart got error=%b code=%0d busy=%b exp 0 0 1", error, err_code, busy);
    end
    repeat (300) tick();
    vec++; if (busy !== 1'b1 || error !== 1'b0) begin
      errs++; $display("FAIL tmo_disabled got busy=%b error=%b exp 1 0", busy, error);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_retry();
    int lk, n, w;
    lk = int'($urandom_range(0, 3));
    w  = lock_latency(lk);
    adpll_lock = 1'b1;
    do_start(3, lk, 0, 20'h3);
    wait_scan(n);
    scan_done = 1'b1;
    tick();
    scan_done = 1'b0;
    repeat (GAP) tick();
    for (int i = 1; i <= RMAX + 1; i++) begin
      wait_scan(n);
      vec++; if (n !== w) begin
        errs++; $display("FAIL retry_relock drop %0d got %0d exp %0d", i, n, w);
      end
      repeat ($urandom_range(0, 2)) tick();
      adpll_lock = 1'b0;
      tick();
      adpll_lock = 1'b1;
      if (i <= RMAX) begin
        vec++; if (scan_en !== 1'b0 || busy !== 1'b1 || retry_cnt !== 2'(i) || run_idx !== 4'd1) begin
          errs++; $display("FAIL retry_count got scan_en=%b busy=%b retry=%0d run=%0d exp 0 1 %0d 1", scan_en, busy, retry_cnt, run_idx, i);
        end
      end else begin
        vec++; if (error !== 1'b1 || err_code !== 2'd2 || scan_en !== 1'b0) begin
          errs++; $display("FAIL retry_error got error=%b code=%0d scan_en=%b exp 1 2 0", error, err_code, scan_en);
        end
      end
    end
  endtask

  task automatic test_coincident();
    int lk, n, w;
    lk = int'($urandom_range(0, 4));
    w  = lock_latency(lk);
    adpll_lock = 1'b1;
    do_start(2, lk, 0, 20'h4);
    for (int r = 0; r < 2; r++) begin
      wait_scan(n);
      vec++; if (n !== w) begin
        errs++; $display("FAIL coin_latency got %0d exp %0d", n, w);
      end
      scan_done = 1'b1; adpll_lock = 1'b0;
      tick();
      scan_done = 1'b0; adpll_lock = 1'b1;
      if (r == 0) begin
        vec++; if (scan_en !== 1'b0 || busy !== 1'b1 || run_idx !== 4'd1 || retry_cnt !== 2'd0) begin
          errs++; $display("FAIL coin_gap got scan_en=%b busy=%b run=%0d retry=%0d exp 0 1 1 0", scan_en, busy, run_idx, retry_cnt);
        end
        repeat (GAP) tick();
      end else begin
        vec++; if (done !== 1'b1 || run_idx !== 4'd2 || retry_cnt !== 2'd0) begin
          errs++; $display("FAIL coin_done got done=%b run=%0d retry=%0d exp 1 2 0", done, run_idx, retry_cnt);
        end
      end
    end
  endtask

  task automatic test_abort();
    int n, lk2, runs2;
    logic [19:0] sn2;
    adpll_lock = 1'b1;
    do_start(3, int'($urandom_range(0, 3)), 0, 20'h5);
    wait_scan(n);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    vec++; if ({scan_en, busy, done, error} !== 4'b0000) begin
      errs++; $display("FAIL abort_idle got %b exp 0000", {scan_en, busy, done, error});
    end
    lk2 = int'($urandom_range(0, 5)); runs2 = int'($urandom_range(1, 3)); sn2 = 20'($urandom);
    do_start(runs2, lk2, 0, sn2);
    vec++; if (busy !== 1'b1 || run_idx !== 4'd0 || scan_num !== sn2 || scan_en !== 1'b0) begin
      errs++; $display("FAIL abort_restart got busy=%b run=%0d num=%h scan_en=%b exp 1 0 %h 0", busy, run_idx, scan_num, scan_en, sn2);
    end
    wait_scan(n);
    vec++; if (n !== lock_latency(lk2)) begin
      errs++; $display("FAIL abort_relock got %0d exp %0d", n, lock_latency(lk2));
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    do_start(0, 0, 0, 20'h6);
    cfg_runs = 4'd1;
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    vec++; if (busy !== 1'b0 || done !== 1'b0) begin
      errs++; $display("FAIL abort_priority got busy=%b done=%b exp 0 0", busy, done);
    end
  endtask

  task automatic test_zero_runs();
    int seen = 0;
    adpll_lock = 1'b1;
    do_start(0, 2, 0, 20'h7);
    vec++; if (done !== 1'b1 || busy !== 1'b0 || scan_en !== 1'b0 || run_idx !== 4'd0) begin
      errs++; $display("FAIL zero_done got done=%b busy=%b scan_en=%b run=%0d exp 1 0 0 0", done, busy, scan_en, run_idx);
    end
    repeat (10) begin
      tick();
      if (scan_en !== 1'b0) seen++;
    end
    vec++; if (seen !== 0 || done !== 1'b1) begin
      errs++; $display("FAIL zero_hold got scan_en_hits=%0d done=%b exp 0 1", seen, done);
    end
    adpll_lock = 1'b0;
    do_start(1, 2, 0, 20'h8);
    vec++; if (busy !== 1'b1 || done !== 1'b0) begin
      errs++; $display("FAIL zero_restart got busy=%b done=%b exp 1 0", busy, done);
    end
    do_start(0, 0, 0, 20'h9);
    vec++; if (busy !== 1'b1 || done !== 1'b0 || scan_num !== 20'h8) begin
      errs++; $display("FAIL busy_start got busy=%b done=%b num=%h exp 1 0 8", busy, done, scan_num);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_lock_pattern();
    logic [63:0] pat;
    int lk, n, e;
    pat = {$urandom, $urandom} | {$urandom, $urandom};
    lk  = int'($urandom_range(0, 5));
    e   = pattern_latency(pat, lk);
    do_start(1, lk, 0, 20'hA);
    n = -1;
    for (int k = 0; k < 200; k++) begin
      if (scan_en === 1'b1) begin
        n = k;
        break;
      end
      adpll_lock = (k < 64) ? pat[k] : 1'b1;
      tick();
    end
    vec++; if (n !== e) begin
      errs++; $display("FAIL lock_pattern lk=%0d pat=%h got %0d exp %0d", lk, pat, n, e);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  initial begin
    test_reset();
    test_async_reset();
    for (int i = 0; i < 4; i++) test_nominal(i);
    test_timeout(100, 1'b0);
    test_timeout(int'($urandom_range(1, 40)), 1'b1);
    test_retry();
    test_coincident();
    test_abort();
    test_zero_runs();
    for (int i = 0; i < 6; i++) test_lock_pattern();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
`default_nettype wire
